// File: rtl/mem_arb_defs.sv
// Shared encodings for the two-port memory arbiter: FSM states, grant owners, memory ops.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arb_defs;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        GNT_NONE  = 2'b00,
        GNT_DATA  = 2'b01,
        GNT_INSTR = 2'b10
    } grant_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

endpackage

// File: rtl/rr_pick2.sv
// Two-requester round-robin selector; pointer names who wins a tie (reset: data port).
// Latency: pick is combinational; pointer moves one cycle after the update strobe.
// Backpressure: none; the caller only strobes upd_i when a transaction retires.
module rr_pick2
    import mem_arb_defs::*;
(
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   dreq_i,
    input  logic   ireq_i,
    input  logic   upd_i,
    input  grant_e owner_i,
    output grant_e pick_o
);

    // 0: data port wins a tie, 1: instruction port wins a tie
    logic ptr_q;

    // Pointer moves to the port that did not own the retiring transaction
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= 1'b0;
        end else if (upd_i) begin
            ptr_q <= (owner_i == GNT_DATA);
        end
    end

    // A lone request always wins; a tie goes to the port the pointer names
    always_comb begin
        pick_o = GNT_NONE;
        if (dreq_i && ireq_i) begin
            pick_o = ptr_q ? GNT_INSTR : GNT_DATA;
        end else if (dreq_i) begin
            pick_o = GNT_DATA;
        end else if (ireq_i) begin
            pick_o = GNT_INSTR;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between the data cache (rd/wr) and instruction cache (rd only).
// Latency: request in IDLE to busywait release is N+3 cycles (N = memory busy cycles).
// Backpressure: the losing or in-flight requester is stalled via its BUSYWAIT until its DONE.
module mem_arbiter
    import mem_arb_defs::*;
#(
    parameter int ADDR_W      = 6,
    parameter int DATA_W      = 32,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              D_READ,
    input  logic              D_WRITE,
    input  logic [ADDR_W-1:0] D_ADDRESS,
    input  logic [DATA_W-1:0] D_WRITEDATA,
    output logic [DATA_W-1:0] D_READDATA,
    output logic              D_BUSYWAIT,
    input  logic              I_READ,
    input  logic [ADDR_W-1:0] I_ADDRESS,
    output logic [DATA_W-1:0] I_READDATA,
    output logic              I_BUSYWAIT,
    output logic              MEM_READ,
    output logic              MEM_WRITE,
    output logic [ADDR_W-1:0] MEM_ADDRESS,
    output logic [DATA_W-1:0] MEM_WRITEDATA,
    input  logic [DATA_W-1:0] MEM_READDATA,
    input  logic              MEM_BUSYWAIT,
    output logic [1:0]        GRANT
);

    localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    state_e            state_q,  state_d;
    grant_e            grant_q,  grant_d;
    op_e               op_q,     op_d;
    logic              rd_q,     rd_d;
    logic              wr_q,     wr_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [DATA_W-1:0] wdata_q,  wdata_d;
    logic [DATA_W-1:0] drdata_q, drdata_d;
    logic [DATA_W-1:0] irdata_q, irdata_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;

    logic   dreq;
    logic   ireq;
    logic   rr_upd;
    logic   complete;
    grant_e pick;

    // Simultaneous read+write from the data cache is treated as a write below
    assign dreq = D_READ | D_WRITE;
    assign ireq = I_READ;

    rr_pick2 u_rr (
        .clk_i   (CLK),
        .rst_ni  (RESET),
        .dreq_i  (dreq),
        .ireq_i  (ireq),
        .upd_i   (rr_upd),
        .owner_i (grant_q),
        .pick_o  (pick)
    );

    // State, latched command and per-port read data registers
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= ST_IDLE;
            grant_q  <= GNT_NONE;
            op_q     <= OP_READ;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            drdata_q <= '0;
            irdata_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            drdata_q <= drdata_d;
            irdata_q <= irdata_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state: arbitrate in IDLE, hold the command until memory finishes, retire in DONE
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        op_d     = op_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        drdata_d = drdata_q;
        irdata_d = irdata_q;
        cnt_d    = cnt_q;
        rr_upd   = 1'b0;
        complete = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick != GNT_NONE) begin
                    grant_d = pick;
                    cnt_d   = '0;
                    state_d = ST_ISSUE;
                    if (pick == GNT_DATA) begin
                        op_d    = D_WRITE ? OP_WRITE : OP_READ;
                        addr_d  = D_ADDRESS;
                        wdata_d = D_WRITEDATA;
                    end else begin
                        op_d    = OP_READ;
                        addr_d  = I_ADDRESS;
                    end
                    rd_d = (op_d == OP_READ);
                    wr_d = (op_d == OP_WRITE);
                end
            end
            ST_ISSUE: begin
                // Memory that never raises busywait is treated as zero-latency after the timeout
                if (MEM_BUSYWAIT) begin
                    state_d = ST_WAIT;
                end else if (cnt_q == CNT_LAST) begin
                    complete = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (!MEM_BUSYWAIT) begin
                    complete = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                grant_d = GNT_NONE;
                rr_upd  = 1'b1;
            end
            default: ;
        endcase

        if (complete) begin
            if (op_q == OP_READ) begin
                if (grant_q == GNT_DATA) begin
                    drdata_d = MEM_READDATA;
                end else begin
                    irdata_d = MEM_READDATA;
                end
            end
            rd_d    = 1'b0;
            wr_d    = 1'b0;
            state_d = ST_DONE;
        end
    end

    assign D_BUSYWAIT    = dreq & ~((state_q == ST_DONE) && (grant_q == GNT_DATA));
    assign I_BUSYWAIT    = ireq & ~((state_q == ST_DONE) && (grant_q == GNT_INSTR));
    assign D_READDATA    = drdata_q;
    assign I_READDATA    = irdata_q;
    assign MEM_READ      = rd_q;
    assign MEM_WRITE     = wr_q;
    assign MEM_ADDRESS   = addr_q;
    assign MEM_WRITEDATA = wdata_q;
    assign GRANT         = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small registered-busywait memory model.
// Latency: memory raises busywait one cycle after seeing a command, for mem_lat cycles.
// Backpressure: n/a.
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        D_READ = 1'b0, D_WRITE = 1'b0, I_READ = 1'b0;
    logic [5:0]  D_ADDRESS = '0, I_ADDRESS = '0;
    logic [31:0] D_WRITEDATA = '0, MEM_READDATA = '0;
    logic [31:0] D_READDATA, I_READDATA, MEM_WRITEDATA;
    logic        D_BUSYWAIT, I_BUSYWAIT, MEM_READ, MEM_WRITE, MEM_BUSYWAIT;
    logic [5:0]  MEM_ADDRESS;
    logic [1:0]  GRANT;

    int pass_cnt = 0;
    int total_cnt = 0;

    int mem_lat = 0;
    int mem_cnt;
    logic mem_act;

    mem_arbiter #(.ADDR_W(6), .DATA_W(32), .ACK_TIMEOUT(4)) dut (
        .CLK(CLK), .RESET(RESET),
        .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDRESS(D_ADDRESS),
        .D_WRITEDATA(D_WRITEDATA), .D_READDATA(D_READDATA), .D_BUSYWAIT(D_BUSYWAIT),
        .I_READ(I_READ), .I_ADDRESS(I_ADDRESS), .I_READDATA(I_READDATA), .I_BUSYWAIT(I_BUSYWAIT),
        .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
        .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA),
        .MEM_BUSYWAIT(MEM_BUSYWAIT), .GRANT(GRANT)
    );

    always #5 CLK = ~CLK;

    // Memory model: busywait rises the cycle after a command appears and stays up mem_lat cycles
    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            mem_act      <= 1'b0;
            mem_cnt      <= 0;
            MEM_BUSYWAIT <= 1'b0;
        end else if (!mem_act) begin
            if ((MEM_READ || MEM_WRITE) && mem_lat > 0) begin
                mem_act      <= 1'b1;
                mem_cnt      <= mem_lat;
                MEM_BUSYWAIT <= 1'b1;
            end
        end else if (mem_cnt > 1) begin
            mem_cnt <= mem_cnt - 1;
        end else begin
            MEM_BUSYWAIT <= 1'b0;
            mem_cnt      <= 0;
            if (!(MEM_READ || MEM_WRITE)) mem_act <= 1'b0;
        end
    end

    task automatic test_reset();
        RESET = 1'b1;
        #2 RESET = 1'b0;
        #1;
        total_cnt++; if (GRANT !== 2'b00) $display("FAIL reset_grant got=%b want=00", GRANT); else pass_cnt++;
        total_cnt++; if ({MEM_READ, MEM_WRITE} !== 2'b00) $display("FAIL reset_cmd got=%b want=00", {MEM_READ, MEM_WRITE}); else pass_cnt++;
        total_cnt++; if (MEM_ADDRESS !== 6'h00 || MEM_WRITEDATA !== 32'h0) $display("FAIL reset_memregs addr=%h wdata=%h want=0", MEM_ADDRESS, MEM_WRITEDATA); else pass_cnt++;
        total_cnt++; if (D_READDATA !== 32'h0 || I_READDATA !== 32'h0) $display("FAIL reset_rdata d=%h i=%h want=0", D_READDATA, I_READDATA); else pass_cnt++;
        total_cnt++; if (D_BUSYWAIT !== 1'b0 || I_BUSYWAIT !== 1'b0) $display("FAIL reset_busywait d=%b i=%b want=0", D_BUSYWAIT, I_BUSYWAIT); else pass_cnt++;
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_simultaneous();
        int n;
        bit ib_ok;
        mem_lat      = 2;
        MEM_READDATA = 32'h5555AAAA;
        D_WRITE = 1'b1; D_ADDRESS = 6'h03; D_WRITEDATA = 32'h11223344;
        I_READ  = 1'b1; I_ADDRESS = 6'h05;
        @(negedge CLK);
        total_cnt++; if (GRANT !== 2'b01) $display("FAIL sim_first_grant got=%b want=01", GRANT); else pass_cnt++;
        total_cnt++; if (MEM_WRITE !== 1'b1 || MEM_READ !== 1'b0 || MEM_ADDRESS !== 6'h03) $display("FAIL sim_write_cmd wr=%b rd=%b addr=%h want 1,0,03", MEM_WRITE, MEM_READ, MEM_ADDRESS); else pass_cnt++;
        total_cnt++; if (MEM_WRITEDATA !== 32'h11223344) $display("FAIL sim_wdata got=%h want=11223344", MEM_WRITEDATA); else pass_cnt++;
        n = 0; ib_ok = 1;
        while (D_BUSYWAIT !== 1'b0 && n < 30) begin
            if (I_BUSYWAIT !== 1'b1) ib_ok = 0;
            @(negedge CLK); n++;
        end
        total_cnt++; if (n >= 30) $display("FAIL sim_data_done_timeout cycles=%0d limit=30", n); else pass_cnt++;
        total_cnt++; if (!ib_ok || I_BUSYWAIT !== 1'b1) $display("FAIL sim_ibusy_during_data got_low=1 want=held_high"); else pass_cnt++;
        D_WRITE = 1'b0;
        n = 0;
        while (GRANT !== 2'b10 && n < 10) begin @(negedge CLK); n++; end
        total_cnt++; if (GRANT !== 2'b10 || MEM_ADDRESS !== 6'h05 || MEM_READ !== 1'b1) $display("FAIL sim_second_grant grant=%b addr=%h rd=%b want 10,05,1", GRANT, MEM_ADDRESS, MEM_READ); else pass_cnt++;
        n = 0; ib_ok = 1;
        while (I_BUSYWAIT !== 1'b0 && n < 30) begin
            if (GRANT !== 2'b10) ib_ok = 0;
            @(negedge CLK); n++;
        end
        total_cnt++; if (n >= 30 || !ib_ok) $display("FAIL sim_instr_done cycles=%0d grant_held=%0d want release with grant 10", n, ib_ok); else pass_cnt++;
        total_cnt++; if (I_READDATA !== 32'h5555AAAA) $display("FAIL sim_irdata got=%h want=5555aaaa", I_READDATA); else pass_cnt++;
        I_READ = 1'b0;
        @(negedge CLK);
        total_cnt++; if (GRANT !== 2'b00) $display("FAIL sim_back_idle got=%b want=00", GRANT); else pass_cnt++;
    endtask

    task automatic test_round_robin();
        logic [1:0] seq [4];
        logic [1:0] prev;
        int n, k;
        mem_lat = 1;
        D_READ = 1'b1; D_ADDRESS = 6'h10;
        I_READ = 1'b1; I_ADDRESS = 6'h11;
        prev = 2'b00; n = 0; k = 0;
        while (n < 4 && k < 200) begin
            @(negedge CLK); k++;
            if (prev == 2'b00 && GRANT != 2'b00) begin seq[n] = GRANT; n++; end
            prev = GRANT;
        end
        D_READ = 1'b0; I_READ = 1'b0;
        total_cnt++; if (n != 4) $display("FAIL rr_timeout grants=%0d want=4", n); else pass_cnt++;
        if (n == 4) begin
            total_cnt++; if (seq[0] !== 2'b01) $display("FAIL rr_g0 got=%b want=01", seq[0]); else pass_cnt++;
            total_cnt++; if (seq[1] !== 2'b10) $display("FAIL rr_g1 got=%b want=10", seq[1]); else pass_cnt++;
            total_cnt++; if (seq[2] !== 2'b01) $display("FAIL rr_g2 got=%b want=01", seq[2]); else pass_cnt++;
            total_cnt++; if (seq[3] !== 2'b10) $display("FAIL rr_g3 got=%b want=10", seq[3]); else pass_cnt++;
        end
        k = 0;
        while (GRANT !== 2'b00 && k < 30) begin @(negedge CLK); k++; end
        total_cnt++; if (k >= 30) $display("FAIL rr_drain_timeout cycles=%0d limit=30", k); else pass_cnt++;
    endtask

    task automatic test_single_read();
        int lows, low_at;
        bit cmd_ok, ib_ok;
        mem_lat = 5;
        MEM_READDATA = 32'hDEADBEEF;
        D_READ = 1'b1; D_ADDRESS = 6'h0A;
        lows = 0; low_at = -1; cmd_ok = 1; ib_ok = 1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge CLK);
            if (D_BUSYWAIT !== 1'b1) begin lows++; low_at = k; end
            if (k <= 7 && (MEM_READ !== 1'b1 || MEM_WRITE !== 1'b0 || MEM_ADDRESS !== 6'h0A)) cmd_ok = 0;
            if (I_BUSYWAIT !== 1'b0) ib_ok = 0;
        end
        total_cnt++; if (lows != 1 || low_at != 8) $display("FAIL rd_release lows=%0d at=%0d want 1 at 8", lows, low_at); else pass_cnt++;
        total_cnt++; if (!cmd_ok) $display("FAIL rd_cmd_stable got=unstable want=MEM_READ=1 addr=0a"); else pass_cnt++;
        total_cnt++; if (D_READDATA !== 32'hDEADBEEF) $display("FAIL rd_data got=%h want=deadbeef", D_READDATA); else pass_cnt++;
        total_cnt++; if (MEM_READ !== 1'b0) $display("FAIL rd_cmd_cleared got=%b want=0", MEM_READ); else pass_cnt++;
        D_READ = 1'b0;
        @(negedge CLK);
        if (I_BUSYWAIT !== 1'b0) ib_ok = 0;
        total_cnt++; if (!ib_ok) $display("FAIL rd_ibusy got=1 want=0"); else pass_cnt++;
        total_cnt++; if (GRANT !== 2'b00 || D_BUSYWAIT !== 1'b0) $display("FAIL rd_idle grant=%b dbusy=%b want 00,0", GRANT, D_BUSYWAIT); else pass_cnt++;
    endtask

    task automatic test_zero_latency();
        int lows, low_at;
        bit cmd_ok;
        mem_lat = 0;
        MEM_READDATA = 32'h0000CAFE;
        I_READ = 1'b1; I_ADDRESS = 6'h07;
        lows = 0; low_at = -1; cmd_ok = 1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge CLK);
            if (I_BUSYWAIT !== 1'b1) begin lows++; low_at = k; end
            if (k <= 4 && (MEM_READ !== 1'b1 || MEM_ADDRESS !== 6'h07)) cmd_ok = 0;
        end
        total_cnt++; if (lows != 1 || low_at != 5) $display("FAIL zl_release lows=%0d at=%0d want 1 at 5", lows, low_at); else pass_cnt++;
        total_cnt++; if (!cmd_ok) $display("FAIL zl_issue_cmd got=unstable want=4 cycles MEM_READ addr 07"); else pass_cnt++;
        total_cnt++; if (I_READDATA !== 32'h0000CAFE) $display("FAIL zl_irdata got=%h want=0000cafe", I_READDATA); else pass_cnt++;
        I_READ = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_withdraw();
        bit rd_ok;
        mem_lat = 5;
        MEM_READDATA = 32'h0BADF00D;
        D_READ = 1'b1; D_ADDRESS = 6'h21;
        rd_ok = 1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge CLK);
            if (k == 3) begin
                total_cnt++; if (MEM_BUSYWAIT !== 1'b1 || GRANT !== 2'b01) $display("FAIL wd_in_wait busy=%b grant=%b want 1,01", MEM_BUSYWAIT, GRANT); else pass_cnt++;
                D_READ = 1'b0;
            end
            if (k <= 8 && MEM_READ !== (k <= 7)) rd_ok = 0;
            if (k == 8) begin
                total_cnt++; if (GRANT !== 2'b01 || D_READDATA !== 32'h0BADF00D) $display("FAIL wd_done grant=%b rdata=%h want 01,0badf00d", GRANT, D_READDATA); else pass_cnt++;
            end
            if (k == 9) begin
                total_cnt++; if (GRANT !== 2'b00 || MEM_READ !== 1'b0) $display("FAIL wd_idle grant=%b rd=%b want 00,0", GRANT, MEM_READ); else pass_cnt++;
            end
        end
        total_cnt++; if (!rd_ok) $display("FAIL wd_cmd_held got=dropped_early want=high until busywait falls"); else pass_cnt++;
    endtask

    task automatic test_write_hold();
        int n;
        bit saw_wr;
        mem_lat = 1;
        D_WRITE = 1'b1; D_ADDRESS = 6'h02; D_WRITEDATA = 32'h00000099;
        n = 0; saw_wr = 0;
        @(negedge CLK);
        while (D_BUSYWAIT !== 1'b0 && n < 30) begin
            if (MEM_WRITE === 1'b1) saw_wr = 1;
            @(negedge CLK); n++;
        end
        total_cnt++; if (n >= 30 || !saw_wr) $display("FAIL wr_complete cycles=%0d saw_write=%0d want done with write", n, saw_wr); else pass_cnt++;
        total_cnt++; if (D_READDATA !== 32'h0BADF00D) $display("FAIL wr_rdata_hold got=%h want=0badf00d", D_READDATA); else pass_cnt++;
        D_WRITE = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_reset_mid_wait();
        mem_lat = 5;
        D_READ = 1'b1; D_ADDRESS = 6'h04;
        repeat (3) @(negedge CLK);
        total_cnt++; if (MEM_READ !== 1'b1 || MEM_BUSYWAIT !== 1'b1) $display("FAIL rst_pre rd=%b busy=%b want 1,1", MEM_READ, MEM_BUSYWAIT); else pass_cnt++;
        #2 RESET = 1'b0;
        #1;
        total_cnt++; if ({MEM_READ, MEM_WRITE} !== 2'b00 || GRANT !== 2'b00) $display("FAIL rst_async cmd=%b grant=%b want 00,00", {MEM_READ, MEM_WRITE}, GRANT); else pass_cnt++;
        D_READ = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        D_READ = 1'b1; I_READ = 1'b1;
        @(negedge CLK);
        total_cnt++; if (GRANT !== 2'b01) $display("FAIL rst_rr_pointer got=%b want=01", GRANT); else pass_cnt++;
        D_READ = 1'b0; I_READ = 1'b0;
    endtask

    initial begin
        test_reset();
        test_simultaneous();
        test_round_robin();
        test_single_read();
        test_zero_latency();
        test_withdraw();
        test_write_hold();
        test_reset_mid_wait();
        repeat (2) @(negedge CLK);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
